// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit owning the HI/LO registers: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, with a one-cycle sign fix-up.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic               neg_q, neg_r, div0, is_div;
  logic [WIDTH-1:0]   a_orig, opd, work_hi, work_lo;

  logic               op_mul, op_div, op_signed, op_any, last_step;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_sh, div_trial;
  logic [2*WIDTH-1:0] product;

  assign op_mul    = (op == 3'd1) || (op == 3'd2);
  assign op_div    = (op == 3'd3) || (op == 3'd4);
  assign op_signed = (op == 3'd1) || (op == 3'd3);
  assign op_any    = op inside {[3'd1:3'd6]};
  assign a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign last_step = (count == CW'(WIDTH - 1));

  // Multiply: {work_hi, work_lo} is {accumulator, multiplier}; opd is the multiplicand.
  assign mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opd : {WIDTH{1'b0}})};
  // Divide: {work_hi, work_lo} is {remainder, quotient/dividend}; opd is the divisor.
  assign div_sh    = {work_hi, work_lo[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, opd};
  assign product   = {work_hi, work_lo};

  assign busy      = (state != S_IDLE);
  // Handshake: an op or MFHI/MFLO is held in EX while stall=1 and is taken
  // on the first edge where busy=0; nothing presented while busy is accepted.
  assign stall     = busy & (mf_req | (op_valid & op_any));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (op_valid && op_mul)      state_nx = S_MUL;
        else if (op_valid && op_div) state_nx = S_DIV;
      end
      S_MUL:   if (last_step) state_nx = S_FIX;
      S_DIV:   if (last_step) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      is_div  <= 1'b0;
      a_orig  <= '0;
      opd     <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (op == 3'd5) hi <= a;
            if (op == 3'd6) lo <= a;
            if (op_mul || op_div) begin
              count   <= '0;
              neg_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r   <= op_signed & a[WIDTH-1];
              div0    <= (b == '0);
              is_div  <= op_div;
              a_orig  <= a;
              work_hi <= '0;
              opd     <= op_div ? b_abs : a_abs;
              work_lo <= op_div ? a_abs : b_abs;
            end
          end
        end
        S_MUL: begin
          work_hi <= mul_sum[WIDTH:1];
          work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          count   <= count + CW'(1);
        end
        S_DIV: begin
          if (!div_trial[WIDTH]) begin
            work_hi <= div_trial[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], 1'b1};
          end else begin
            work_hi <= div_sh[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], 1'b0};
          end
          count <= count + CW'(1);
        end
        S_FIX: begin
          if (is_div) begin
            if (div0) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= neg_q ? -work_lo : work_lo;
              hi <= neg_r ? -work_hi : work_hi;
            end
          end else begin
            {hi, lo} <= neg_q ? -product : product;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed cases plus random ops checked cycle by cycle
// against an arithmetic reference of HI/LO, busy and stall.
module tb_mdu_seq;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, op_valid, mf_req;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, stall;
  logic [1:0]   state_dbg;

  int           vectors = 0;
  int           miscompares = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  model_hilo;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .mf_req(mf_req), .busy(busy), .stall(stall), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} of one op given the current {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd1: return 64'(sx * sy);
      3'd2: return ux * uy;
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      3'd5: return {x, cur[31:0]};
      3'd6: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic busy_exp, input logic stall_exp,
                             input logic [63:0] hilo_exp);
    check({tag, " busy"}, 64'(busy), 64'(busy_exp));
    check({tag, " stall"}, 64'(stall), 64'(stall_exp));
    check({tag, " hilo"}, {hi, lo}, hilo_exp);
  endtask

  // Starts #1 after a rising edge (cycle 0) and ends #1 after the edge that
  // opens the cycle following the op's completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit rand_mf);
    logic        iter;
    int          last;
    logic [63:0] pre;
    iter = (o >= 3'd1) && (o <= 3'd4);
    last = iter ? LAT : 1;
    pre  = model_hilo;
    exp_q.push_back(ref_result(o, x, y, model_hilo));
    op_valid = 1'b1; op = o; a = x; b = y;
    mf_req = rand_mf ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    check_cycle({tag, " c0"}, 1'b0, 1'b0, pre);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    for (int k = 1; k <= last; k++) begin
      mf_req = rand_mf ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (k == last) model_hilo = exp_q.pop_front();
      check_cycle(tag, iter && (k < last), iter && (k < last) && mf_req,
                  (k < last) ? pre : model_hilo);
      @(posedge clk); #1;
    end
    mf_req = 1'b0;
  endtask

  initial begin
    logic [63:0] pre, res1, res2;
    logic        bexp;
    rst = 1'b1; op_valid = 1'b0; op = 3'd0; a = '0; b = '0; mf_req = 1'b0;
    model_hilo = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_cycle("reset", 1'b0, 1'b0, 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);
    @(posedge clk); #1;

    run_op("mult_neg3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg3x5 value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max value", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7, 1'b0);
    check("divu_100_7 value", {hi, lo}, {32'd2, 32'd14});
    run_op("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7_2 value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf value", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op("div_by0", 3'd3, 32'h1234_5678, 32'd0, 1'b0);
    check("div_by0 value", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    run_op("divu_by0", 3'd4, 32'hCAFE_0001, 32'd0, 1'b0);

    // MFHI/MFLO arriving in cycle 5 of a MULT is held until the product lands.
    pre = model_hilo;
    res1 = ref_result(3'd1, 32'd7, 32'hFFFF_FFFB, pre);
    op_valid = 1'b1; op = 3'd1; a = 32'd7; b = 32'hFFFF_FFFB;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    for (int k = 1; k <= LAT; k++) begin
      mf_req = (k >= 5);
      @(negedge clk);
      check_cycle("mf_stall", k <= LAT - 1, (k >= 5) && (k <= LAT - 1), (k < LAT) ? pre : res1);
      @(posedge clk); #1;
    end
    mf_req = 1'b0;
    model_hilo = res1;

    // A second MULT presented in cycle 3 waits and is taken when busy falls.
    pre  = model_hilo;
    res1 = ref_result(3'd1, 32'h0001_2345, 32'h0000_0100, pre);
    res2 = ref_result(3'd1, 32'hFFFF_0000, 32'h0000_0003, res1);
    op_valid = 1'b1; op = 3'd1; a = 32'h0001_2345; b = 32'h0000_0100;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    for (int k = 1; k <= 2 * LAT; k++) begin
      op_valid = (k >= 3) && (k <= LAT);
      op = op_valid ? 3'd1 : 3'd0;
      a  = op_valid ? 32'hFFFF_0000 : 32'd0;
      b  = op_valid ? 32'h0000_0003 : 32'd0;
      bexp = (k <= LAT - 1) || ((k >= LAT + 1) && (k <= 2 * LAT - 1));
      @(negedge clk);
      check_cycle("op_stall", bexp, bexp && op_valid,
                  (k < LAT) ? pre : ((k < 2 * LAT) ? res1 : res2));
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op = 3'd0;
    model_hilo = res2;

    run_op("mtlo", 3'd6, 32'h0000_ABCD, 32'd0, 1'b1);
    check("mtlo lo", 64'(lo), 64'h0000_ABCD);
    run_op("mthi", 3'd5, 32'h0000_0011, 32'd0, 1'b1);
    run_op("mtlo11", 3'd6, 32'h0000_0011, 32'd0, 1'b1);
    run_op("nop7", 3'd7, 32'h5555_5555, 32'd1, 1'b1);

    // Reset during cycle 10 of a DIVU discards it.
    op_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    for (int k = 1; k <= 10; k++) begin
      rst = (k == 10);
      @(negedge clk);
      check_cycle("rst_mid", 1'b1, 1'b0, {32'h11, 32'h11});
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    model_hilo = 64'd0;
    check_cycle("rst_after", 1'b0, 1'b0, 64'd0);
    check("rst_after state", 64'(state_dbg), 64'd0);
    @(posedge clk); #1;
    run_op("mult_2x3", 3'd1, 32'd2, 32'd3, 1'b0);
    check("mult_2x3 value", {hi, lo}, {32'd0, 32'd6});

    for (int n = 0; n < 24; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op("random", ro, ra, rb, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
